// File: rtl/pipe_stage_hs.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_hs
//  Brief    : Parametrised pipeline stage register with valid/ready handshake,
//             masked flush-to-bubble and an optional 2-entry skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_hs #(
  parameter int unsigned  W          = 64,
  parameter logic [W-1:0] RESET_VAL  = '0,
  parameter logic [W-1:0] FLUSH_MASK = '1,
  parameter int unsigned  SKID       = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam bit c_has_skid = (SKID != 0);

  state_t       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  // Held low through reset and for the release cycle so nothing is accepted
  // before the first clean clock edge.
  logic         live_q, live_d;

  logic         w_in_fire;

  // Skid variant decouples in_ready from out_ready; single-entry variant
  // lets a consume in the same cycle make room for a replacement.
  generate
    if (c_has_skid) begin : g_skid_ready
      assign in_ready = live_q & (state_q != ST_TWO) & ~flush;
    end else begin : g_pass_ready
      assign in_ready = live_q & ((state_q == ST_EMPTY) | out_ready) & ~flush;
    end
  endgenerate

  assign w_in_fire = in_valid & in_ready;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

  // Occupancy reported straight from the state.
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and payload update; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    live_d  = 1'b1;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = (main_q & ~FLUSH_MASK) | (RESET_VAL & FLUSH_MASK);
      skid_d  = (skid_q & ~FLUSH_MASK) | (RESET_VAL & FLUSH_MASK);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (w_in_fire && out_ready) begin
            main_d = in_data;
          end else if (w_in_fire && c_has_skid) begin
            // Downstream stalled: park the newcomer behind the main entry.
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            // Skid entry is younger, so it only moves up once main drains.
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and payload registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      live_q  <= live_d;
    end
  end

endmodule
`default_nettype wire
